run_ctrl: RTL and testbench

- Synthesizable run controller for CPU simulation and FPGA bring-up.
- Accepts a memory image as a word stream and writes it into CPU memory through a write port.
- Then sequences CPU reset for a programmable number of cycles, runs the CPU under a cycle-limit watchdog, and reports halt or timeout.
- Generalises the bench-level "load hex, hold reset, run to limit" flow to parametrised width, depth and limit, with runtime limit override and an abort path.

---
 rtl/run_ctrl_pkg.sv | 25 ++
 rtl/run_ctrl_watchdog.sv | 36 +++
 rtl/run_ctrl.sv | 154 +++++++++++++++
 tb/tb_run_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run controller: sequencing states and
// cycle-limit selection.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RESET,
    RUN,
    HALTED,
    TIMEOUT
  } run_state_t;

  // Widest cycle limit the helper handles; callers narrow the result.
  localparam int unsigned LIMIT_MAX_W = 64;

  // A zero runtime limit means "use the built-in default".
  function automatic logic [LIMIT_MAX_W-1:0] limit_sel(
    input logic [LIMIT_MAX_W-1:0] limit_in,
    input logic [LIMIT_MAX_W-1:0] default_limit
  );
    return (limit_in == '0) ? default_limit : limit_in;
  endfunction

endpackage

// File: rtl/run_ctrl_watchdog.sv
// Run-phase watchdog: holds the latched cycle limit, counts RUN cycles with
// saturation, and flags the cycle on which the count reaches the limit.
module run_watchdog #(
  parameter int unsigned LIMIT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               count_en,
  input  logic [LIMIT_W-1:0] limit_in,
  output logic [LIMIT_W-1:0] cycles,
  output logic               expire
);

  logic [LIMIT_W-1:0] limit_q;
  logic [LIMIT_W-1:0] cycles_next;

  assign cycles_next = (&cycles) ? cycles : cycles + LIMIT_W'(1);

  // Expiry looks at the value the counter is about to take, so the
  // controller leaves RUN on the same edge the count reaches the limit.
  assign expire = count_en && (cycles_next == limit_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      limit_q <= '0;
      cycles  <= '0;
    end else if (clear) begin
      limit_q <= limit_in;
      cycles  <= '0;
    end else if (count_en) begin
      cycles <= cycles_next;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: streams a memory image into CPU memory, holds CPU reset,
// runs under a cycle-limit watchdog. Optional csum output: RUN_CTRL_CHECKSUM_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned AW            = 15,
  parameter int unsigned DW            = 48,
  parameter int unsigned LIMIT_W       = 32,
  parameter int unsigned RESET_CYCLES  = 10,
  parameter int unsigned DEFAULT_LIMIT = 100000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LIMIT_W-1:0] limit_i,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [AW-1:0]      ld_addr,
  input  logic [DW-1:0]      ld_data,
  input  logic               ld_last,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               cpu_reset,
  input  logic               cpu_halt,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [LIMIT_W-1:0] cycles
`ifdef RUN_CTRL_CHECKSUM_EN
  ,
  output logic [DW-1:0]      csum
`endif
);

  localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);

  run_state_t         state;
  logic [RCW-1:0]     rst_cnt;
  logic               handshake;
  logic               accept;
  logic               go;
  logic               count_en;
  logic               expire;
  logic [LIMIT_W-1:0] limit_pick;

  assign ld_ready  = (state == LOAD);
  assign busy      = state inside {LOAD, RESET, RUN};
  assign handshake = ld_ready & ld_valid;
  // Abort outranks everything, including a word offered in the same cycle.
  assign accept    = handshake & ~abort;
  assign go        = (state == IDLE) & start & ~abort;
  assign count_en  = (state == RUN) & ~abort;

  assign limit_pick = LIMIT_W'(limit_sel(LIMIT_MAX_W'(limit_i),
                                         LIMIT_MAX_W'(DEFAULT_LIMIT)));

  run_watchdog #(
    .LIMIT_W (LIMIT_W)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (go),
    .count_en (count_en),
    .limit_in (limit_pick),
    .cycles   (cycles),
    .expire   (expire)
  );

  // NOTE: every register below is assigned with <= so all of them sample the
  // pre-edge values; a blocking = here would let later lines see new state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      cpu_reset <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= ld_addr;
        mem_wdata <= ld_data;
      end

      if (abort) begin
        state     <= IDLE;
        cpu_reset <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cpu_reset <= 1'b1;
            if (start) begin
              state   <= LOAD;
              done    <= 1'b0;
              timeout <= 1'b0;
            end
          end
          LOAD: begin
            if (handshake && ld_last) begin
              state   <= RESET;
              rst_cnt <= RCW'(RESET_CYCLES - 1);
            end
          end
          RESET: begin
            if (rst_cnt == '0) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt - RCW'(1);
            end
          end
          RUN: begin
            // Halt is tested first so it wins a tie with the limit.
            if (cpu_halt) begin
              state     <= HALTED;
              done      <= 1'b1;
              cpu_reset <= 1'b1;
            end else if (expire) begin
              state     <= TIMEOUT;
              timeout   <= 1'b1;
              cpu_reset <= 1'b1;
            end
          end
          HALTED, TIMEOUT: begin
            cpu_reset <= 1'b1;
          end
          default: begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef RUN_CTRL_CHECKSUM_EN
  // Running image signature: csum ^= rotl1(csum) ^ word for each accepted word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (go) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum ^ {csum[DW-2:0], csum[DW-1]} ^ ld_data;
    end
  end
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: a transaction-level reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_run_ctrl;

  localparam int     AW        = 15;
  localparam int     DW        = 48;
  localparam int     LW        = 32;
  localparam int     RC        = 10;
  localparam longint DEF_LIMIT = 100000;
  localparam longint MAXC      = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, ld_valid, ld_last, cpu_halt;
  logic [LW-1:0] limit_i;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready, mem_we, cpu_reset, busy, done, timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [LW-1:0] cycles;

  always #5 clk = ~clk;

  run_ctrl #(
    .AW(AW), .DW(DW), .LIMIT_W(LW), .RESET_CYCLES(RC), .DEFAULT_LIMIT(100000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .limit_i(limit_i), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .busy(busy),
    .done(done), .timeout(timeout), .cycles(cycles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_LOAD, P_RESET, P_RUN, P_HALTED, P_TIMEOUT} phase_e;
  typedef struct {
    phase_e        ph;
    int            left;
    longint        run;
    longint        limit;
    bit            done;
    bit            to;
    bit            we;
    bit            cpu_rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            live;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c);
    model_t n = c;
    if (!reset_n) begin
      n.ph = P_IDLE; n.cpu_rst = 1'b1; n.we = 1'b0;
      n.done = 1'b0; n.to = 1'b0; n.run = 0; n.live = 1'b1;
      return n;
    end
    n.we = (c.ph == P_LOAD) && ld_valid && !abort;
    if (n.we) begin
      n.addr = ld_addr;
      n.data = ld_data;
    end
    if (abort) begin
      n.ph = P_IDLE; n.cpu_rst = 1'b1;
      return n;
    end
    case (c.ph)
      P_IDLE: if (start) begin
        n.ph = P_LOAD; n.done = 1'b0; n.to = 1'b0; n.run = 0;
        n.limit = (limit_i == '0) ? DEF_LIMIT : longint'(limit_i);
      end
      P_LOAD: if (ld_valid && ld_last) begin
        n.ph = P_RESET; n.left = RC;
      end
      P_RESET: begin
        n.left = c.left - 1;
        if (n.left == 0) begin n.ph = P_RUN; n.cpu_rst = 1'b0; end
      end
      P_RUN: begin
        n.run = (c.run >= MAXC) ? MAXC : c.run + 1;
        if (cpu_halt) begin
          n.ph = P_HALTED; n.done = 1'b1; n.cpu_rst = 1'b1;
        end else if (n.run == c.limit) begin
          n.ph = P_TIMEOUT; n.to = 1'b1; n.cpu_rst = 1'b1;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  // ---------------- per-cycle compare and write log ----------------
  int            cyc_n = 0;
  int            wr_count = 0;
  int            last_we_cyc = 0;
  int            fall_cyc = 0;
  bit            prev_cr = 1'b0;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];

  always @(negedge clk) begin
    cyc_n++;
    if (m.live) begin
      check("cpu_reset", 64'(cpu_reset), 64'(m.cpu_rst));
      check("mem_we",    64'(mem_we),    64'(m.we));
      check("ld_ready",  64'(ld_ready),  64'(m.ph == P_LOAD));
      check("busy",      64'(busy),      64'(m.ph inside {P_LOAD, P_RESET, P_RUN}));
      check("done",      64'(done),      64'(m.done));
      check("timeout",   64'(timeout),   64'(m.to));
      check("cycles",    64'(cycles),    64'(m.run));
      if (m.we) begin
        check("mem_addr",  64'(mem_addr),  64'(m.addr));
        check("mem_wdata", 64'(mem_wdata), 64'(m.data));
      end
    end
    if (mem_we === 1'b1) begin
      wr_count++;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc_n);
      last_we_cyc = cyc_n;
    end
    if (prev_cr && cpu_reset === 1'b0) fall_cyc = cyc_n;
    prev_cr = (cpu_reset === 1'b1);
  end

  // ---------------- stimulus ----------------
  logic [AW-1:0] w_addr[$];
  logic [DW-1:0] w_data[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    cpu_halt = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic go_idle();
    if (m.ph != P_IDLE) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    tick();
  endtask

  // valid_mode: 0 always valid, 1 every other cycle, 2 random.
  task automatic run_seq(input longint lim, input int halt_after, input int valid_mode,
                         input int abort_pct, input int start_pct,
                         input int abort_word, input int reset_run);
    int idx = 0;
    bit pend = 1'b0;
    bit ended = 1'b0;
    int n = w_addr.size();
    start = 1'b1;
    limit_i = LW'(lim);
    tick();
    start = 1'b0;
    limit_i = $urandom;
    for (int k = 0; k < 4000; k++) begin
      if (pend) idx++;
      pend = 1'b0;
      if (m.ph inside {P_IDLE, P_HALTED, P_TIMEOUT}) begin
        ended = 1'b1;
        break;
      end
      reset_n = 1'b1;
      abort = ($urandom_range(99) < abort_pct) ||
              (abort_word >= 0 && idx == abort_word && m.ph == P_LOAD);
      start = ($urandom_range(99) < start_pct);
      if (idx < n) begin
        ld_addr = w_addr[idx];
        ld_data = w_data[idx];
        ld_last = (idx == n - 1);
        case (valid_mode)
          0:       ld_valid = 1'b1;
          1:       ld_valid = (k % 2 == 0);
          default: ld_valid = 1'($urandom_range(1));
        endcase
      end else begin
        ld_addr  = AW'($urandom);
        ld_data  = {16'($urandom), 32'($urandom)};
        ld_last  = 1'($urandom_range(1));
        ld_valid = 1'($urandom_range(1));
      end
      if (m.ph == P_RUN) cpu_halt = (halt_after > 0 && m.run == longint'(halt_after - 1));
      else               cpu_halt = 1'($urandom_range(1));
      if (reset_run > 0 && m.ph == P_RUN && m.run == longint'(reset_run)) reset_n = 1'b0;
      pend = ld_valid && (ld_ready === 1'b1) && !abort && reset_n;
      tick();
    end
    idle_inputs();
    reset_n = 1'b1;
    check("seq_finished", 64'(ended), 64'd1);
  endtask

  task automatic rand_image(input int n);
    w_addr.delete();
    w_data.delete();
    for (int i = 0; i < n; i++) begin
      w_addr.push_back(AW'($urandom));
      w_data.push_back({16'($urandom), 32'($urandom)});
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int nq;
    reset_n = 1'b0;
    limit_i = '0;
    idle_inputs();
    repeat (3) tick();

    // Reset values
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_ld_ready",  64'(ld_ready),  64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_timeout",   64'(timeout),   64'd0);
    check("rst_cycles",    64'(cycles),    64'd0);
    reset_n = 1'b1;
    tick();

    // Normal run: default limit, three words, halt after 50 RUN cycles
    w_addr = '{15'h0010, 15'h0011, 15'h7FFF};
    w_data = '{48'h1111_2222_3333, 48'hABCD_EF01_2345, 48'hFFFF_0000_FFFF};
    base = wr_count;
    run_seq(0, 50, 0, 0, 0, -1, 0);
    check("norm_wr_count", 64'(wr_count - base), 64'd3);
    nq = wr_addr_q.size();
    check("norm_addr0", 64'(wr_addr_q[nq-3]), 64'h10);
    check("norm_addr1", 64'(wr_addr_q[nq-2]), 64'h11);
    check("norm_addr2", 64'(wr_addr_q[nq-1]), 64'h7FFF);
    check("norm_data0", 64'(wr_data_q[nq-3]), 64'h1111_2222_3333);
    check("norm_data2", 64'(wr_data_q[nq-1]), 64'hFFFF_0000_FFFF);
    check("norm_consecutive", 64'(wr_cyc_q[nq-1] - wr_cyc_q[nq-3]), 64'd2);
    check("norm_reset_len", 64'(fall_cyc - last_we_cyc), 64'd10);
    check("norm_done",    64'(done),    64'd1);
    check("norm_timeout", 64'(timeout), 64'd0);
    check("norm_cycles",  64'(cycles),  64'd50);
    check("norm_cpu_rst", 64'(cpu_reset), 64'd1);

    // start is ignored while halted
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("halted_start_busy", 64'(busy),   64'd0);
    check("halted_start_done", 64'(done),   64'd1);
    // abort returns to IDLE but keeps status and count
    go_idle();
    check("abort_keep_done",   64'(done),   64'd1);
    check("abort_keep_cycles", 64'(cycles), 64'd50);

    // Timeout: limit 20, never halts
    rand_image(2);
    run_seq(20, 0, 0, 0, 0, -1, 0);
    check("to_timeout", 64'(timeout),   64'd1);
    check("to_done",    64'(done),      64'd0);
    check("to_cycles",  64'(cycles),    64'd20);
    check("to_cpu_rst", 64'(cpu_reset), 64'd1);
    go_idle();

    // Coincidence: halt on the cycle the limit is reached
    rand_image(1);
    run_seq(20, 20, 0, 0, 0, -1, 0);
    check("coin_done",    64'(done),    64'd1);
    check("coin_timeout", 64'(timeout), 64'd0);
    check("coin_cycles",  64'(cycles),  64'd20);
    go_idle();

    // Limit of one RUN cycle
    rand_image(1);
    run_seq(1, 0, 0, 0, 0, -1, 0);
    check("lim1_timeout", 64'(timeout), 64'd1);
    check("lim1_cycles",  64'(cycles),  64'd1);
    go_idle();

    // Stalled stream: valid every other cycle
    rand_image(4);
    base = wr_count;
    run_seq(30, 5, 1, 0, 0, -1, 0);
    check("stall_wr_count", 64'(wr_count - base), 64'd4);
    go_idle();

    // Abort in mid-LOAD on the third word
    rand_image(5);
    base = wr_count;
    run_seq(30, 5, 0, 0, 0, 2, 0);
    check("abort_mem_we",   64'(mem_we),    64'd0);
    check("abort_busy",     64'(busy),      64'd0);
    check("abort_ld_ready", 64'(ld_ready),  64'd0);
    check("abort_cpu_rst",  64'(cpu_reset), 64'd1);
    ld_valid = 1'b1;
    ld_last  = 1'b1;
    repeat (4) tick();
    idle_inputs();
    check("abort_wr_count", 64'(wr_count - base), 64'd2);
    go_idle();

    // Reset in mid-RUN
    rand_image(2);
    run_seq(500, 0, 0, 0, 0, -1, 5);
    check("rrun_cpu_rst", 64'(cpu_reset), 64'd1);
    check("rrun_busy",    64'(busy),      64'd0);
    check("rrun_mem_we",  64'(mem_we),    64'd0);
    check("rrun_done",    64'(done),      64'd0);
    check("rrun_timeout", 64'(timeout),   64'd0);
    check("rrun_cycles",  64'(cycles),    64'd0);
    tick();

    // Randomized sequences
    for (int it = 0; it < 40; it++) begin
      longint lim;
      int     halt;
      lim  = ($urandom_range(3) == 0) ? 0 : longint'($urandom_range(60, 1));
      halt = (lim == 0) ? int'($urandom_range(80, 1))
                        : (($urandom_range(2) == 0) ? 0 : int'($urandom_range(70, 1)));
      rand_image(int'($urandom_range(6, 1)));
      run_seq(lim, halt, 2, 2, 5, -1, 0);
      go_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
